sseg_scan_capture: RTL and testbench

- Reads a multiplexed, active-low seven-segment display bus (segment lines plus digit strobes) and rebuilds the displayed value as packed BCD, one nibble per digit.
- Inverse of the BCD-to-seven-segment decoder. Used by self-test logic and host readback to confirm what the display is actually showing.
- Each digit is captured only after its pattern has stayed stable for a set number of samples.
- A complete frame goes out through a valid/ready register, with blank and error flags.

---
 rtl/sseg_scan_capture.sv | 217 +++++++++++++++++++++
 tb/tb_sseg_scan_capture.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture
// Reads a multiplexed, active-low seven-segment bus (segments + digit strobes)
// and rebuilds the displayed value as packed BCD, one nibble per digit.
// A digit is captured once its strobe/pattern pair has been stable for STABLE
// samples. Complete frames leave through a valid/ready output register.
// Optional build macro: SSEG_SCAN_SYNC_EN adds a two-flop synchronizer in
// front of the input register (flops reset to all ones, an idle bus).
module sseg_scan_capture #(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_n,
    input  logic [DIGITS-1:0]   an_n,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   blank_out,
    output logic                err_out,
    output logic                out_valid,
    input  logic                out_ready
);
    localparam int         IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] STABLE_C = 8'(STABLE);

    logic [6:0]        seg_in;
    logic [DIGITS-1:0] an_in;

`ifdef SSEG_SCAN_SYNC_EN
    logic [6:0]        seg_s1_q, seg_s2_q;
    logic [DIGITS-1:0] an_s1_q, an_s2_q;

    // Two-flop synchronizer for pins driven from another clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            an_s1_q  <= '1;
            an_s2_q  <= '1;
        end else begin
            seg_s1_q <= seg_n;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= an_n;
            an_s2_q  <= an_s1_q;
        end
    end

    assign seg_in = seg_s2_q;
    assign an_in  = an_s2_q;
`else
    assign seg_in = seg_n;
    assign an_in  = an_n;
`endif

    logic [6:0]        seg_q;
    logic [DIGITS-1:0] an_q;
    logic              smp_vld_q;

    // Input register. smp_vld_q masks the all-zero reset contents of an_q,
    // which would otherwise decode as a strobe collision and taint a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= '0;
            an_q      <= '0;
            smp_vld_q <= 1'b0;
        end else begin
            seg_q     <= seg_in;
            an_q      <= an_in;
            smp_vld_q <= 1'b1;
        end
    end

    logic [3:0]    low_cnt;
    logic [IW-1:0] idx;
    logic          sel;
    logic          coll;

    // Strobe decode: one low bit selects a digit, none is idle, more is a collision.
    always_comb begin
        low_cnt = '0;
        idx     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                low_cnt = low_cnt + 4'd1;
                idx     = IW'(i);
            end
        end
        sel  = smp_vld_q && (low_cnt == 4'd1);
        coll = smp_vld_q && (low_cnt > 4'd1);
    end

    logic [3:0] nib;
    logic       blank;
    logic       bad;

    // Pattern decode, inverse of the BCD-to-seven-segment table (bit 6 = g).
    always_comb begin
        nib   = 4'hE;
        blank = 1'b0;
        bad   = 1'b0;
        case (seg_q)
            7'b1000000: nib = 4'd0;
            7'b1111001: nib = 4'd1;
            7'b0100100: nib = 4'd2;
            7'b0110000: nib = 4'd3;
            7'b0011001: nib = 4'd4;
            7'b0010010: nib = 4'd5;
            7'b0000010: nib = 4'd6;
            7'b1111000: nib = 4'd7;
            7'b0000000: nib = 4'd8;
            7'b0010000: nib = 4'd9;
            7'b1111111: begin
                nib   = 4'hF;
                blank = 1'b1;
            end
            default:    bad = 1'b1;
        endcase
    end

    logic [7:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q;
    logic [6:0]    pat_q;
    logic          same;
    logic          cap;

    // Stability counter. A restart on a new selection may itself complete the
    // count (STABLE=1), so a restart is always allowed to capture.
    always_comb begin
        same  = (cnt_q != 8'd0) && (idx == idx_q) && (seg_q == pat_q);
        cnt_d = 8'd0;
        if (sel) begin
            if (!same)
                cnt_d = 8'd1;
            else if (cnt_q < STABLE_C)
                cnt_d = cnt_q + 8'd1;
            else
                cnt_d = cnt_q;
        end
        cap = sel && (cnt_d == STABLE_C) && (!same || (cnt_q < STABLE_C));
    end

    // Counter and previous-sample registers used for the "same as last" test.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            pat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx;
            pat_q <= seg_q;
        end
    end

    logic [DIGITS-1:0]   cap_vec;
    logic [4*DIGITS-1:0] slot_flat;
    logic [DIGITS-1:0]   slot_blank;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
            logic [3:0] nib_q;
            logic       blank_q;

            assign cap_vec[gi] = cap && (idx == IW'(gi));

            // Slot keeps the most recent capture of this digit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    nib_q   <= 4'h0;
                    blank_q <= 1'b0;
                end else if (cap_vec[gi]) begin
                    nib_q   <= nib;
                    blank_q <= blank;
                end
            end

            assign slot_flat[4*gi +: 4] = nib_q;
            assign slot_blank[gi]       = blank_q;
        end
    endgenerate

    logic [DIGITS-1:0] captured_q, captured_d;
    logic              err_acc_q, err_acc_d;
    logic              err_now;
    logic              xfer;

    // Frame bookkeeping: events in a transfer cycle belong to the next frame.
    always_comb begin
        err_now    = coll || (cap && bad);
        xfer       = (&captured_q) && (!out_valid || out_ready);
        captured_d = xfer ? cap_vec : (captured_q | cap_vec);
        err_acc_d  = xfer ? err_now : (err_acc_q | err_now);
    end

    // Frame state and valid/ready output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            captured_q <= '0;
            err_acc_q  <= 1'b0;
            bcd_out    <= '0;
            blank_out  <= '0;
            err_out    <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            captured_q <= captured_d;
            err_acc_q  <= err_acc_d;
            if (xfer) begin
                bcd_out   <= slot_flat;
                blank_out <= slot_blank;
                err_out   <= err_acc_q;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture (DIGITS=4, STABLE=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sseg_scan_capture;
    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic        err_out;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sseg_scan_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .bcd_out   (bcd_out),
        .blank_out (blank_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int d, input int v, input int n);
        drive(4'(~(4'b0001 << d)), seg_of(v), n);
    endtask

    task automatic scan(input int v0, input int v1, input int v2, input int v3);
        show(0, v0, 8);
        show(1, v1, 8);
        show(2, v2, 8);
        show(3, v3, 8);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] bcd,
                             input logic [3:0] blk, input logic err);
        check({tag, "/valid"}, 32'(out_valid), 32'd1);
        check({tag, "/bcd"},   32'(bcd_out),   32'(bcd));
        check({tag, "/blank"}, 32'(blank_out), 32'(blk));
        check({tag, "/err"},   32'(err_out),   32'(err));
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        an_n      = '1;
        seg_n     = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset/valid", 32'(out_valid), 32'd0);
        check("reset/bcd",   32'(bcd_out),   32'd0);
        check("reset/blank", 32'(blank_out), 32'd0);
        check("reset/err",   32'(err_out),   32'd0);
        drive(4'hF, 7'h7F, 2);

        // Basic frame 1,2,3,4: valid exactly one edge after digit 3 capture.
        show(0, 1, 8);
        show(1, 2, 8);
        show(2, 3, 8);
        show(3, 4, 5);
        check("basic/pre_valid", 32'(out_valid), 32'd0);
        show(3, 4, 1);
        chk_frame("basic", 16'h4321, 4'b0000, 1'b0);
        show(3, 4, 2);
        drive(4'hF, 7'h7F, 2);
        accept();
        check("basic/accepted", 32'(out_valid), 32'd0);

        // Blank on digit 2, invalid pattern on digit 1.
        show(0, 1, 8);
        drive(4'b1101, 7'b0101010, 8);
        show(2, 15, 8);
        show(3, 4, 8);
        chk_frame("blank_inv", 16'h4FE1, 4'b0100, 1'b1);
        accept();
        check("blank_inv/accepted", 32'(out_valid), 32'd0);

        // Glitch: 3 + 2 cycle dwells on digit 0 must not capture.
        drive(4'hF, 7'h7F, 2);
        show(0, 5, 3);
        show(0, 6, 2);
        show(1, 8, 8);
        show(2, 9, 8);
        show(3, 0, 8);
        check("glitch/no_frame", 32'(out_valid), 32'd0);
        show(0, 7, 5);
        show(0, 7, 1);
        chk_frame("glitch", 16'h0987, 4'b0000, 1'b0);
        accept();

        // Strobe collision inside a frame, then a clean frame.
        show(0, 1, 8);
        drive(4'b1100, seg_of(2), 10);
        show(1, 2, 8);
        show(2, 3, 8);
        show(3, 4, 8);
        chk_frame("collision", 16'h4321, 4'b0000, 1'b1);
        accept();
        scan(0, 0, 0, 1);
        chk_frame("clean", 16'h1000, 4'b0000, 1'b0);
        accept();

        // Back-pressure: second frame waits, loads on the accepting edge.
        scan(5, 6, 7, 8);
        chk_frame("bp_first", 16'h8765, 4'b0000, 1'b0);
        scan(9, 0, 1, 2);
        check("bp_hold/valid", 32'(out_valid), 32'd1);
        check("bp_hold/bcd",   32'(bcd_out),   32'h8765);
        accept();
        chk_frame("bp_second", 16'h2109, 4'b0000, 1'b0);

        // Reset after two digits captured discards the partial frame.
        show(0, 3, 8);
        show(1, 4, 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst/valid", 32'(out_valid), 32'd0);
        check("midrst/bcd",   32'(bcd_out),   32'd0);
        check("midrst/blank", 32'(blank_out), 32'd0);
        check("midrst/err",   32'(err_out),   32'd0);
        show(2, 5, 8);
        show(3, 6, 8);
        check("midrst/partial", 32'(out_valid), 32'd0);
        show(0, 3, 8);
        show(1, 4, 8);
        chk_frame("midrst_full", 16'h6543, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
